fir_coef_ctrl: RTL
==================

FIR_COEF_CTRL -- requirements
Module: fir_coef_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 8, number of unique symmetric coefficients.
REQ-002 SHALL have parameter CW, default 12, signed coefficient width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port cfg_valid, input, 1, a coefficient word is offered.
REQ-006 SHALL have port cfg_ready, output, 1, the block accepts a coefficient word.
REQ-007 SHALL have port cfg_data, input, CW, signed coefficient, index order 0..NTAPS-1.
REQ-008 SHALL have port cfg_last, input, 1, marks the final word of a set.
REQ-009 SHALL have port cfg_abort, input, 1, discards a pending load or armed set.
REQ-010 SHALL have port sample_strobe, input, 1, one-cycle pulse at each FIR sample boundary.
REQ-011 SHALL have port coe_bus, output, NTAPS*CW, active coefficients, coe[i] at bits [i*CW+CW-1 : i*CW].
REQ-012 SHALL have port bank_sel, output, 1, active bank index.
REQ-013 SHALL have port swap_done, output, 1, one-cycle pulse after a bank swap.
REQ-014 SHALL have port err_len, output, 1, one-cycle pulse on a length error.

Function
REQ-015 SHALL hold two banks (A/B) of NTAPS x CW registers: one active (drives coe_bus), one shadow.
REQ-016 SHALL implement FSM states IDLE, LOAD, ARMED.
REQ-017 SHALL accept a word only on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-018 SHALL drive cfg_ready=1 in IDLE and LOAD, 0 in ARMED and during reset.
REQ-019 SHALL write an accepted word to shadow[cnt] and increment cnt (0..NTAPS-1).
REQ-020 SHALL move IDLE->LOAD on the first accepted word unless that word completes the set.
REQ-021 SHALL move to ARMED when the word accepted at cnt=NTAPS-1 carries cfg_last=1.
REQ-022 SHALL pulse err_len, clear cnt and go IDLE if cfg_last=1 arrives at cnt<NTAPS-1, or cfg_last=0 arrives at cnt=NTAPS-1.
REQ-023 SHALL leave active bank untouched on any length error.
REQ-024 SHALL, in ARMED with sample_strobe=1, toggle bank_sel at that edge and return to IDLE with cnt=0.
REQ-025 SHALL pulse swap_done in the cycle after the swapping edge.
REQ-026 SHALL change coe_bus only at a swap edge (zero glitch between samples).
REQ-027 SHALL, on cfg_abort=1 in LOAD or ARMED, clear cnt and go IDLE with no swap.
REQ-028 SHALL give cfg_abort priority over sample_strobe and over a simultaneous accepted word.
REQ-029 SHALL ignore sample_strobe in IDLE and LOAD.
REQ-030 SHALL treat NTAPS=1 as complete on the first word with cfg_last=1.

Reset
REQ-031 SHALL on rst=0 set state IDLE, cnt=0, bank_sel=0, swap_done=0, err_len=0, cfg_ready=0.
REQ-032 SHALL on reset load bank A with 000, FFD, 00F, 02E, F8B, EF9, 24E, 7FF (hex, index 0..7) and bank B with zeros.
REQ-033 SHALL set cfg_ready=1 on the first clock edge after rst releases.

Configuration
REQ-034 SHALL, with macro FIR_COEF_READBACK_EN defined, add inputs rd_addr (clog2(NTAPS) bits) and output rd_data (CW) returning active[rd_addr] registered, 1-cycle latency, reset 0.
REQ-035 SHALL, without FIR_COEF_READBACK_EN, omit rd_addr/rd_data and all readback logic.

Verification
REQ-036 Reset release -> coe_bus = 7FF_24E_EF9_F8B_02E_00F_FFD_000, bank_sel=0, cfg_ready=1 after one edge.
REQ-037 Load 8 words 001..008, last on 8th, strobe 5 cycles later -> bank_sel=1 at strobe edge, coe[3]=004, swap_done pulses next cycle.
REQ-038 Load 5 words, last on 5th -> err_len pulse, state IDLE, coe_bus unchanged, bank_sel=0.
REQ-039 Full set armed, cfg_abort and sample_strobe same cycle -> no swap, bank_sel=0, cfg_ready=1 next cycle.
REQ-040 cfg_valid held high while ARMED -> no word accepted until swap, then next set loads from index 0.
REQ-041 rst=0 asserted mid-LOAD after 4 words -> immediate defaults, cnt=0, no swap_done; with FIR_COEF_READBACK_EN, rd_addr=7 -> rd_data=7FF one cycle later.

Source files
------------

// File: rtl/fir_coef_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fir_coef_ctrl
// Purpose  : Double-banked coefficient store for a symmetric FIR filter.
//            Coefficient words are streamed into the shadow bank over a
//            valid/ready handshake. A complete set arms the block. The banks
//            are swapped on the next sample strobe, so coe_bus only changes
//            at a sample boundary.
// Ports    : clk, rst (async, active-low)
//            cfg_valid/cfg_ready/cfg_data/cfg_last : coefficient load stream
//            cfg_abort     : discard a pending load or an armed set
//            sample_strobe : FIR sample boundary, swap point for an armed set
//            coe_bus       : active coefficients, coe[i] at [i*CW +: CW]
//            bank_sel      : active bank (0 = A, 1 = B)
//            swap_done     : one-cycle pulse in the cycle after a swap
//            err_len       : one-cycle pulse when a set has the wrong length
//            rd_addr/rd_data : registered readback of the active bank, only
//                              present when FIR_COEF_READBACK_EN is defined
// Options  : FIR_COEF_READBACK_EN enables the readback port.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coef_ctrl #(
    parameter int NTAPS = 8,
    parameter int CW    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CW-1:0]         cfg_data,
    input  logic                  cfg_last,
    input  logic                  cfg_abort,
    input  logic                  sample_strobe,
    output logic [NTAPS*CW-1:0]   coe_bus,
    output logic                  bank_sel,
    output logic                  swap_done,
    output logic                  err_len
`ifdef FIR_COEF_READBACK_EN
    ,
    input  logic [((NTAPS > 1) ? $clog2(NTAPS) : 1)-1:0] rd_addr,
    output logic [CW-1:0]         rd_data
`endif
);

    localparam int CNTW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              bank_sel_q, bank_sel_d;
    logic              swap_done_q, swap_done_d;
    logic              err_len_q, err_len_d;
    logic              cfg_ready_q, cfg_ready_d;
    logic [CW-1:0]     bank_a_q [NTAPS];
    logic [CW-1:0]     bank_a_d [NTAPS];
    logic [CW-1:0]     bank_b_q [NTAPS];
    logic [CW-1:0]     bank_b_d [NTAPS];

    logic              accept;
    logic              last_idx;
    logic              wr_en;

    // Power-up coefficient set for bank A. The table is held as 12-bit values
    // and is sign-extended or truncated to CW.
    function automatic logic [CW-1:0] reset_coef(input int idx);
        logic [11:0] v;
        case (idx)
            0:       v = 12'h000;
            1:       v = 12'hFFD;
            2:       v = 12'h00F;
            3:       v = 12'h02E;
            4:       v = 12'hF8B;
            5:       v = 12'hEF9;
            6:       v = 12'h24E;
            7:       v = 12'h7FF;
            default: v = 12'h000;
        endcase
        return CW'($signed(v));
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bank_sel_d  = bank_sel_q;
        swap_done_d = 1'b0;
        err_len_d   = 1'b0;
        bank_a_d    = bank_a_q;
        bank_b_d    = bank_b_q;
        wr_en       = 1'b0;
        accept      = cfg_valid & cfg_ready_q;
        last_idx    = (cnt_q == CNTW'(NTAPS - 1));

        // An abort takes priority over both a strobe and a word offered in
        // the same cycle. That word is dropped, not written.
        if (cfg_abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (cfg_last != last_idx) begin
                            // The set is either too short or too long. The
                            // active bank is never touched.
                            err_len_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = IDLE;
                        end else if (last_idx) begin
                            wr_en   = 1'b1;
                            cnt_d   = '0;
                            state_d = ARMED;
                        end else begin
                            wr_en   = 1'b1;
                            cnt_d   = cnt_q + CNTW'(1);
                            state_d = LOAD;
                        end
                    end
                end
                ARMED: begin
                    if (sample_strobe) begin
                        bank_sel_d  = ~bank_sel_q;
                        swap_done_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end

        // Writes always go to the shadow bank, which is the bank not selected.
        if (wr_en) begin
            if (bank_sel_q) begin
                bank_a_d[cnt_q] = cfg_data;
            end else begin
                bank_b_d[cnt_q] = cfg_data;
            end
        end

        // Ready is registered, so it stays low through reset and rises on
        // the first edge after reset is released.
        cfg_ready_d = (state_d != ARMED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bank_sel_q  <= 1'b0;
            swap_done_q <= 1'b0;
            err_len_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                bank_a_q[i] <= reset_coef(i);
                bank_b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bank_sel_q  <= bank_sel_d;
            swap_done_q <= swap_done_d;
            err_len_q   <= err_len_d;
            cfg_ready_q <= cfg_ready_d;
            bank_a_q    <= bank_a_d;
            bank_b_q    <= bank_b_d;
        end
    end

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coe
            assign coe_bus[gi*CW +: CW] = bank_sel_q ? bank_b_q[gi] : bank_a_q[gi];
        end
    endgenerate

    assign cfg_ready = cfg_ready_q;
    assign bank_sel  = bank_sel_q;
    assign swap_done = swap_done_q;
    assign err_len   = err_len_q;

`ifdef FIR_COEF_READBACK_EN
    logic [CW-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = bank_sel_q ? bank_b_q[rd_addr] : bank_a_q[rd_addr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
`endif

endmodule
`default_nettype wire
